// File: rtl/sobel_window_ctrl.sv
// Scan sequencer for the 3x3 Sobel window: pixel/line/frame counting, window
// qualification, centre-coordinate reporting and line/frame completion pulses.
module sobel_window_ctrl #(
  parameter int ROW_SIZE = 180,
  parameter int NUM_ROWS = 120,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             pixel_valid,
  output logic [COL_W-1:0] col_addr,
  output logic [ROW_W-1:0] row_addr,
  output logic             shift_en,
  output logic             window_valid,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             line_done,
  output logic             frame_done,
  output logic             busy,
  output logic             restart_err
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;
  state_t state;

  logic last_col, last_row, full_win;
  assign last_col = (col_addr == COL_W'(ROW_SIZE - 1));
  assign last_row = (row_addr == ROW_W'(NUM_ROWS - 1));
  // Columns 0/1 would pull taps wrapped from the previous line.
  assign full_win = (row_addr >= ROW_W'(2)) && (col_addr >= COL_W'(2));

  assign shift_en = pixel_valid && (state != IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      col_addr     <= '0;
      row_addr     <= '0;
      win_col      <= '0;
      win_row      <= '0;
      window_valid <= 1'b0;
      line_done    <= 1'b0;
      frame_done   <= 1'b0;
      restart_err  <= 1'b0;
    end else begin
      window_valid <= 1'b0;
      line_done    <= 1'b0;
      frame_done   <= 1'b0;
      restart_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state    <= PRIME;
            col_addr <= '0;
            row_addr <= '0;
          end
        end
        DONE: state <= IDLE;
        default: begin
          if (frame_start) begin
            // Restart mid-frame: a coincident pixel is taken as (0,0).
            restart_err <= 1'b1;
            state       <= PRIME;
            row_addr    <= '0;
            col_addr    <= pixel_valid ? COL_W'(1) : '0;
          end else if (pixel_valid) begin
            window_valid <= full_win;
            if (full_win) begin
              win_col <= col_addr - COL_W'(1);
              win_row <= row_addr - ROW_W'(1);
            end
            if (last_col) begin
              line_done <= 1'b1;
              col_addr  <= '0;
              if (state == RUN && last_row) begin
                row_addr   <= '0;
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                row_addr <= row_addr + ROW_W'(1);
                if (state == PRIME && row_addr == ROW_W'(1)) state <= RUN;
              end
            end else begin
              col_addr <= col_addr + COL_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl: directed phases plus random
// pixel_valid/frame_start traffic against a pixel-index reference model.
module tb_sobel_window_ctrl;
  localparam int RS = 180;
  localparam int NR = 120;
  localparam int CW = 10;
  localparam int RW = 9;
  localparam int NPIX = RS * NR;
  localparam int NWIN = (RS - 2) * (NR - 2);

  logic clock = 1'b0;
  logic reset, frame_start, pixel_valid;
  logic [CW-1:0] col_addr, win_col;
  logic [RW-1:0] row_addr, win_row;
  logic shift_en, window_valid, line_done, frame_done, busy, restart_err;

  sobel_window_ctrl #(.ROW_SIZE(RS), .NUM_ROWS(NR), .COL_W(CW), .ROW_W(RW)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .col_addr(col_addr), .row_addr(row_addr), .shift_en(shift_en),
    .window_valid(window_valid), .win_col(win_col), .win_row(win_row),
    .line_done(line_done), .frame_done(frame_done), .busy(busy), .restart_err(restart_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is a linear pixel index; row/col derived by div/mod.
  bit m_busy = 0, m_done = 0;
  int m_p = 0;
  int e_wc = 0, e_wr = 0;
  bit e_wv = 0, e_ld = 0, e_fd = 0, e_re = 0;
  int wv_cnt = 0, fd_cnt = 0, first_wc = -1, first_wr = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rs, input bit fs, input bit pv);
    int r, c;
    reset = rs; frame_start = fs; pixel_valid = pv;
    #1;
    chk("shift_en", {31'b0, shift_en}, {31'b0, pv && m_busy});
    e_wv = 0; e_ld = 0; e_fd = 0; e_re = 0;
    if (rs) begin
      m_busy = 0; m_done = 0; m_p = 0; e_wc = 0; e_wr = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (fs) begin m_busy = 1; m_p = 0; end
    end else if (fs) begin
      e_re = 1;
      m_p = pv ? 1 : 0;
    end else if (pv) begin
      r = m_p / RS; c = m_p % RS;
      if (r >= 2 && c >= 2) begin e_wv = 1; e_wc = c - 1; e_wr = r - 1; end
      if (c == RS - 1) e_ld = 1;
      m_p++;
      if (m_p == NPIX) begin m_p = 0; m_done = 1; e_fd = 1; end
    end
    @(posedge clock); #1;
    chk("col_addr", 32'(col_addr), 32'(m_p % RS));
    chk("row_addr", 32'(row_addr), 32'(m_p / RS));
    chk("window_valid", {31'b0, window_valid}, {31'b0, e_wv});
    chk("win_col", 32'(win_col), 32'(e_wc));
    chk("win_row", 32'(win_row), 32'(e_wr));
    chk("line_done", {31'b0, line_done}, {31'b0, e_ld});
    chk("frame_done", {31'b0, frame_done}, {31'b0, e_fd});
    chk("restart_err", {31'b0, restart_err}, {31'b0, e_re});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    if (window_valid) begin
      if (first_wc < 0) begin first_wc = int'(win_col); first_wr = int'(win_row); end
      wv_cnt++;
    end
    if (frame_done) fd_cnt++;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0;
    // Reset state
    repeat (3) step(1, 0, 0);

    // Full frame, back-to-back pixels
    step(0, 1, 0);
    repeat (NPIX) step(0, 0, 1);
    chk("frame1_windows", 32'(wv_cnt), 32'(NWIN));
    chk("frame1_first_col", 32'(first_wc), 32'd1);
    chk("frame1_first_row", 32'(first_wr), 32'd1);
    chk("frame1_done_count", 32'(fd_cnt), 32'd1);
    // frame_start during the DONE cycle is dropped
    step(0, 1, 1);
    step(0, 0, 1);
    chk("idle_after_done", {31'b0, busy}, 32'd0);

    // pixel_valid toggling across a line end
    step(0, 1, 0);
    for (int i = 0; i < 2 * RS + 20; i++) step(0, 0, i[0] == 1'b0);

    // Restart at row 50, col 90 with a coincident pixel
    step(1, 0, 0);
    step(0, 1, 0);
    repeat (50 * RS + 90) step(0, 0, 1);
    chk("pre_restart_row", 32'(row_addr), 32'd50);
    chk("pre_restart_col", 32'(col_addr), 32'd90);
    step(0, 1, 1);
    chk("post_restart_col", 32'(col_addr), 32'd1);
    repeat (3 * RS) step(0, 0, 1);

    // Reset mid-RUN, then pixels while idle are ignored
    step(1, 0, 1);
    repeat (10) step(0, 0, 1);
    chk("idle_col_zero", 32'(col_addr), 32'd0);

    // Random traffic with rare restarts and gaps
    step(0, 1, 0);
    for (int i = 0; i < 30000; i++)
      step(0, ($urandom_range(0, 2999) == 0) || !busy, $urandom_range(0, 3) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
